sipo_collect: RTL and testbench



---
 rtl/sipo_collect.sv | 83 ++++++++
 tb/tb_sipo_collect.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/sipo_collect.sv
// rtl/sipo_collect.sv - serial-to-parallel word collector with valid/ready on both sides; define SIPO_MSB_FIRST_EN for MSB-first ordering
module sipo_collect #(
  parameter int width = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sin,
  input  logic                     sin_valid,
  output logic                     sin_ready,
  input  logic                     flush,
  output logic [width-1:0]         q,
  output logic                     q_valid,
  input  logic                     q_ready,
  output logic [$clog2(width)-1:0] count
);

  localparam int cw = $clog2(width);
  localparam logic [cw-1:0] last_count = cw'(width - 1);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [width-1:0] sr;
  logic [width-1:0] sr_shift;
  logic             accept;
  logic             complete;

  // Partial word with the incoming bit merged in; the shift direction sets bit ordering
  always_comb begin
`ifdef SIPO_MSB_FIRST_EN
    sr_shift = (sr << 1) | width'(sin);
`else
    sr_shift = (sr >> 1) | (width'(sin) << (width - 1));
`endif
  end

  // Handshake decode and next-state: FULL leaves only on an output handshake
  always_comb begin
    sin_ready  = !flush && (state == FILL || q_ready);
    accept     = sin_valid && sin_ready;
    complete   = accept && (count == last_count);
    state_next = state;
    case (state)
      FILL: if (complete) state_next = FULL;
      FULL: if (q_ready && !complete) state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  assign q_valid = (state == FULL);

  // State register; FULL doubles as q_valid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FILL;
    else       state <= state_next;
  end

  // Shift register, bit counter and frozen output word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr    <= '0;
      count <= '0;
      q     <= '0;
    end else if (flush) begin
      sr    <= '0;
      count <= '0;
    end else if (accept) begin
      if (complete) begin
        q     <= sr_shift;
        sr    <= '0;
        count <= '0;
      end else begin
        sr    <= sr_shift;
        count <= count + cw'(1);
      end
    end
  end

endmodule

// File: tb/tb_sipo_collect.sv
// tb/tb_sipo_collect.sv - self-checking bench for sipo_collect against a bit-queue reference model
module tb_sipo_collect;

  localparam int W = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 sin, sin_valid, flush, q_ready;
  logic                 sin_ready, q_valid;
  logic [W-1:0]         q;
  logic [$clog2(W)-1:0] count;

  int total = 0;
  int bad = 0;

  // reference model: accepted bits of the current partial word, plus the held output
  bit           bits[$];
  logic [W-1:0] m_q;
  logic         m_valid;

  sipo_collect #(.width(W)) dut (
    .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .sin_ready(sin_ready),
    .flush(flush), .q(q), .q_valid(q_valid), .q_ready(q_ready), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pack_word();
    logic [W-1:0] w;
    w = '0;
    for (int k = 0; k < W; k++) begin
`ifdef SIPO_MSB_FIRST_EN
      w[W-1-k] = bits[k];
`else
      w[k] = bits[k];
`endif
    end
    return w;
  endfunction

  task automatic model_reset();
    bits.delete();
    m_q = '0;
    m_valid = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".q"}, 32'(q), 32'(m_q));
    check({tag, ".q_valid"}, 32'(q_valid), 32'(m_valid));
    check({tag, ".count"}, 32'(count), 32'(bits.size()));
  endtask

  // one clock cycle: drive, check ready before the edge, advance model, check state after
  task automatic cycle(input logic b, input logic v, input logic rdy, input logic fl, input string tag);
    logic exp_rdy;
    sin = b; sin_valid = v; q_ready = rdy; flush = fl;
    #1;
    exp_rdy = !fl && (!m_valid || rdy);
    check({tag, ".sin_ready"}, 32'(sin_ready), 32'(exp_rdy));
    @(posedge clk);
    if (m_valid && rdy) m_valid = 1'b0;
    if (fl) bits.delete();
    else if (v && exp_rdy) begin
      bits.push_back(b);
      if (bits.size() == W) begin
        m_q = pack_word();
        m_valid = 1'b1;
        bits.delete();
      end
    end
    #1;
    check_outputs(tag);
  endtask

  logic [3:0] pat;
  logic [W-1:0] lit;

  initial begin
    reset = 1'b1; sin = 1'b0; sin_valid = 1'b0; flush = 1'b0; q_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    check("reset.sin_ready", 32'(sin_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;

    // first word 1,0,1,1 held with q_ready low
    pat = 4'b1101;
    for (int i = 0; i < 4; i++) cycle(pat[i], 1'b1, 1'b0, 1'b0, "word1");
`ifdef SIPO_MSB_FIRST_EN
    lit = 4'b1011;
`else
    lit = 4'b1101;
`endif
    check("word1.literal", 32'(q), 32'(lit));
    check("word1.andn_y", 32'(&q), 32'(lit == 4'b1111));

    // back-pressure: five stalled cycles, then handshake with a pass-through bit
    for (int i = 0; i < 5; i++) cycle(1'($urandom), 1'b1, 1'b0, 1'b0, "stall");
    cycle(1'b1, 1'b1, 1'b1, 1'b0, "release");

    // flush the leftover bit, then 12 bits at full rate
    cycle(1'b1, 1'b1, 1'b1, 1'b1, "flush0");
    for (int i = 0; i < 12; i++) begin
      cycle(1'($urandom), 1'b1, 1'b1, 1'b0, "stream");
      check("stream.pulse", 32'(q_valid), 32'((i % 4) == 3));
    end

    // two bits, flush with a bit offered, then a clean word 0,1,1,0
    cycle(1'b1, 1'b1, 1'b1, 1'b0, "pre");
    cycle(1'b1, 1'b1, 1'b1, 1'b0, "pre");
    cycle(1'b1, 1'b1, 1'b1, 1'b1, "flush");
    pat = 4'b0110;
    for (int i = 0; i < 4; i++) cycle(pat[i], 1'b1, 1'b0, 1'b0, "clean");
`ifdef SIPO_MSB_FIRST_EN
    lit = 4'b0110;
`else
    lit = 4'b0110;
`endif
    check("clean.literal", 32'(q), 32'(lit));

    // three bits into the next word, then asynchronous reset between edges
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, "part");
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    check("async_rst.sin_ready", 32'(sin_ready), 32'd1);
    #1 reset = 1'b0;

    // all-ones word gives y=1, then 1,0,1,1 gives y=0
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, "ones");
    check("andn.ones", 32'(&q), 32'd1);
    pat = 4'b1101;
    cycle(pat[0], 1'b1, 1'b1, 1'b0, "word2");
    for (int i = 1; i < 4; i++) cycle(pat[i], 1'b1, 1'b0, 1'b0, "word2");
    check("andn.word2", 32'(&q), 32'd0);
    check("andn.model", 32'(&q), 32'(&m_q));

    // randomized traffic against the model
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 15) == 0), "random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
